// File: rtl/jpeg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jpeg_pkg
// Brief    : Shared constants and types for the JPEG run-length decoder.
// Revision : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

    localparam int COEF_W    = 12;
    localparam int BLOCK_LEN = 64;
    localparam int IDX_W     = $clog2(BLOCK_LEN);
    localparam int ZRL_LEN   = 16;

    // Special AC symbols, both carrying size 0
    localparam logic [3:0] c_eob_run  = 4'd0;
    localparam logic [3:0] c_eob_size = 4'd0;
    localparam logic [3:0] c_zrl_run  = 4'd15;
    localparam logic [3:0] c_zrl_size = 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ZEROS = 2'd1,
        VALUE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]        run;
        logic [3:0]        size;
        logic [COEF_W-1:0] bits;
    } symbol_t;

endpackage
`default_nettype wire

// File: rtl/jpeg_amp_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jpeg_amp_decode
// Brief    : Combinational JPEG amplitude decode of (size, additional bits).
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_amp_decode #(
    parameter int COEF_W = 12
) (
    input  logic [3:0]        i_size,
    input  logic [COEF_W-1:0] i_bits,
    output logic [COEF_W-1:0] o_coef,
    output logic              o_err
);

    localparam logic [3:0] c_max_size = 4'(COEF_W - 1);

    logic [COEF_W-1:0] w_mask;
    logic [COEF_W-1:0] w_mag;
    logic [COEF_W-1:0] w_top;

    always_comb begin
        w_mask = (COEF_W'(1) << i_size) - COEF_W'(1);
        w_mag  = i_bits & w_mask;
        w_top  = w_mag >> (i_size - 4'd1);
        o_coef = '0;
        o_err  = 1'b0;
        if (i_size > c_max_size) begin
            o_err = 1'b1;
        end else if (i_size != 4'd0) begin
            // Leading bit clear means negative: value is bits - (2^size - 1)
            o_coef = w_top[0] ? w_mag : (w_mag - w_mask);
        end
    end

endmodule
`default_nettype wire

// File: rtl/jpeg_rle_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jpeg_rle_decoder
// Brief    : Expands (run, size, bits) symbols into 64 zig-zag coefficients.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_rle_decoder
    import jpeg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_run,
    input  logic [3:0]               in_size,
    input  logic [COEF_W-1:0]        in_bits,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_coef,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic                     err
);

    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(BLOCK_LEN - 1);
    localparam logic [IDX_W:0]   c_block_len = (IDX_W+1)'(BLOCK_LEN);
    localparam logic [IDX_W:0]   c_zrl_len   = (IDX_W+1)'(ZRL_LEN);
    localparam logic [IDX_W:0]   c_one_cnt   = (IDX_W+1)'(1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_pos;
    logic [IDX_W:0]    r_zcnt;
    logic              r_has_val;
    logic [COEF_W-1:0] r_val;
    logic [COEF_W-1:0] r_out_coef;
    logic [IDX_W-1:0]  r_out_index;
    logic              r_out_last;
    logic              r_err;

    logic [COEF_W-1:0] w_amp;
    logic              w_amp_err;
    logic              w_xfer;
    logic              w_final;
    logic              w_done;
    logic              w_accept;
    logic [IDX_W-1:0]  w_next_idx;
    logic [IDX_W-1:0]  w_base;
    logic [IDX_W:0]    w_room;
    logic [IDX_W:0]    w_run;
    logic [IDX_W:0]    w_zeros;
    logic              w_has_val;
    logic              w_sym_err;

    jpeg_amp_decode #(
        .COEF_W (COEF_W)
    ) u_amp (
        .i_size (in_size),
        .i_bits (in_bits),
        .o_coef (w_amp),
        .o_err  (w_amp_err)
    );

    assign out_valid = (r_state != IDLE);
    assign out_coef  = r_out_coef;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;
    assign err       = r_err;

    // The final coefficient of a symbol frees the input in the same cycle
    assign w_xfer   = out_valid && out_ready;
    assign w_final  = (r_state == VALUE) ||
                      ((r_state == ZEROS) && (r_zcnt == c_one_cnt) && !r_has_val);
    assign w_done   = w_xfer && w_final;
    assign in_ready = (r_state == IDLE) || w_done;
    assign w_accept = in_valid && in_ready;

    assign w_next_idx = (r_out_index == c_last_idx) ? '0 : (r_out_index + IDX_W'(1));
    assign w_base     = (r_state == IDLE) ? r_pos : w_next_idx;
    assign w_room     = c_block_len - {1'b0, w_base};
    assign w_run      = (IDX_W+1)'(in_run);

    // Classify the incoming symbol against the position it will start at
    always_comb begin
        w_zeros   = '0;
        w_has_val = 1'b0;
        w_sym_err = w_amp_err;
        if (w_base == '0) begin
            w_has_val = 1'b1;
        end else if (in_size != c_eob_size) begin
            if (w_run >= w_room) begin
                w_zeros   = w_room;
                w_sym_err = 1'b1;
            end else begin
                w_zeros   = w_run;
                w_has_val = 1'b1;
            end
        end else if ((in_run == c_zrl_run) && (in_size == c_zrl_size)) begin
            if (c_zrl_len > w_room) begin
                w_zeros   = w_room;
                w_sym_err = 1'b1;
            end else begin
                w_zeros = c_zrl_len;
            end
        end else begin
            w_zeros   = w_room;
            w_sym_err = (in_run != c_eob_run);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pos       <= '0;
            r_zcnt      <= '0;
            r_has_val   <= 1'b0;
            r_val       <= '0;
            r_out_coef  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept && w_sym_err) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_has_val   <= w_has_val;
                r_val       <= w_amp;
                r_zcnt      <= w_zeros;
                r_out_index <= w_base;
                r_out_last  <= (w_base == c_last_idx);
                if (w_zeros != '0) begin
                    r_state    <= ZEROS;
                    r_out_coef <= '0;
                end else begin
                    r_state    <= VALUE;
                    r_out_coef <= w_amp;
                end
            end else if (w_xfer) begin
                if (w_final) begin
                    r_state <= IDLE;
                    r_pos   <= w_next_idx;
                end else begin
                    r_out_index <= w_next_idx;
                    r_out_last  <= (w_next_idx == c_last_idx);
                    if (r_zcnt > c_one_cnt) begin
                        r_zcnt <= r_zcnt - c_one_cnt;
                    end else begin
                        r_zcnt     <= '0;
                        r_state    <= VALUE;
                        r_out_coef <= r_val;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_rle_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_rle_decoder
// Brief    : Randomized self-checking bench with a symbol-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_rle_decoder;
    import jpeg_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               in_run;
    logic [3:0]               in_size;
    logic [COEF_W-1:0]        in_bits;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [COEF_W-1:0] out_coef;
    logic [IDX_W-1:0]         out_index;
    logic                     out_last;
    logic                     err;

    typedef struct {
        int coef;
        int idx;
        bit last;
        bit fin;
    } exp_t;

    exp_t    exp_q[$];
    symbol_t sym_q[$];
    int      m_pos;
    int      m_err;
    int      checks = 0;
    int      errors = 0;

    always #5 clk = ~clk;

    jpeg_rle_decoder u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_run    (in_run),
        .in_size   (in_size),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_index (out_index),
        .out_last  (out_last),
        .err       (err)
    );

    task automatic check_value(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int amp(input int size, input int bits);
        int b;
        if (size == 0 || size > 11) return 0;
        b = bits % (1 << size);
        if (b >= (1 << (size - 1))) return b;
        return b - ((1 << size) - 1);
    endfunction

    function automatic void push_exp(input int coef, input bit fin);
        exp_t e;
        e.coef = coef;
        e.idx  = m_pos;
        e.last = (m_pos == 63);
        e.fin  = fin;
        exp_q.push_back(e);
        m_pos = (m_pos + 1) % 64;
    endfunction

    // Symbol-level model: how many zeros, whether a value follows, and error
    function automatic void model_symbol(input symbol_t s);
        int  run, size, room, nz, a;
        bit  val;
        run  = int'(s.run);
        size = int'(s.size);
        room = 64 - m_pos;
        a    = amp(size, int'(s.bits));
        nz   = 0;
        val  = 0;
        if (size > 11) m_err = 1;
        if (m_pos == 0) begin
            val = 1;
        end else if (size != 0) begin
            if (m_pos + run > 63) begin
                nz = room;
                m_err = 1;
            end else begin
                nz  = run;
                val = 1;
            end
        end else if (run == 15) begin
            if (16 > room) begin
                nz = room;
                m_err = 1;
            end else begin
                nz = 16;
            end
        end else begin
            nz = room;
            if (run != 0) m_err = 1;
        end
        for (int i = 0; i < nz; i++) push_exp(0, !val && (i == nz - 1));
        if (val) push_exp(a, 1'b1);
    endfunction

    task automatic add_sym(input int run, input int size, input int bits);
        symbol_t s;
        s.run  = 4'(run);
        s.size = 4'(size);
        s.bits = COEF_W'(bits);
        sym_q.push_back(s);
    endtask

    task automatic clear_model();
        exp_q.delete();
        sym_q.delete();
        m_pos = 0;
        m_err = 0;
    endtask

    task automatic run_stream(input int budget, input int ready_pct, input int gap_pct,
                              input int stop_at, output int xfers, output int first_c,
                              output int last_c);
        int cyc;
        bit stalled;
        int s_coef, s_idx;
        bit s_last;
        bit exp_rdy;
        cyc = 0;
        stalled = 0;
        s_coef = 0;
        s_idx = 0;
        s_last = 0;
        xfers = 0;
        first_c = -1;
        last_c = -1;
        while ((sym_q.size() > 0 || exp_q.size() > 0) && cyc < budget && xfers != stop_at) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < ready_pct);
            if (sym_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_run   = sym_q[0].run;
                in_size  = sym_q[0].size;
                in_bits  = sym_q[0].bits;
            end else begin
                in_valid = 1'b0;
                in_run   = 4'($urandom);
                in_size  = 4'($urandom);
                in_bits  = COEF_W'($urandom);
            end
            #1;
            if (stalled) begin
                check_value("stall_coef", out_coef, s_coef);
                check_value("stall_index", out_index, s_idx);
                check_value("stall_last", out_last, s_last);
                stalled = 0;
            end
            check_value("out_valid", out_valid, exp_q.size() != 0);
            exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q[0].fin);
            check_value("in_ready", in_ready, exp_rdy);
            if (out_valid && exp_q.size() > 0) begin
                check_value("coef", out_coef, exp_q[0].coef);
                check_value("index", out_index, exp_q[0].idx);
                check_value("last", out_last, exp_q[0].last);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (first_c < 0) first_c = cyc;
                    last_c = cyc;
                    xfers++;
                end else begin
                    stalled = 1;
                    s_coef  = int'(out_coef);
                    s_idx   = int'(out_index);
                    s_last  = out_last;
                end
            end
            if (in_valid && in_ready) model_symbol(sym_q.pop_front());
            cyc++;
        end
        if (stop_at < 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            check_value("drained", sym_q.size() + exp_q.size(), 0);
            check_value("err", err, m_err);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_in_ready", in_ready, 1);
        check_value("rst_err", err, 0);
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        int n, f, l, r, k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_run    = '0;
        in_size   = '0;
        in_bits   = '0;
        out_ready = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_value("reset_out_valid", out_valid, 0);
        check_value("reset_in_ready", in_ready, 1);
        check_value("reset_err", err, 0);
        check_value("reset_coef", out_coef, 0);
        check_value("reset_index", out_index, 0);
        check_value("reset_last", out_last, 0);
        rst = 1'b0;

        // DC -5 then EOB, followed by a second block that must start as DC
        add_sym(0, 3, 3'b010);
        add_sym(0, 0, 0);
        add_sym(0, 2, 1);
        add_sym(0, 0, 0);
        run_stream(2000, 100, 0, -1, n, f, l);
        check_value("t1_xfers", n, 128);

        // DC size 0 with a nonzero run field, then run=2 +1, then EOB
        add_sym(5, 0, 0);
        add_sym(2, 1, 1);
        add_sym(0, 0, 0);
        run_stream(2000, 100, 0, -1, n, f, l);
        check_value("t2_xfers", n, 64);

        // 63 back-to-back run=0 values: one coefficient per cycle
        add_sym(0, 4, 9);
        for (int i = 0; i < 63; i++) add_sym(0, 1, 0);
        run_stream(2000, 100, 0, -1, n, f, l);
        check_value("t3_xfers", n, 64);
        check_value("t3_span", l - f, 63);

        // EOB fill under random backpressure
        add_sym(0, 6, 37);
        add_sym(0, 0, 0);
        run_stream(4000, 50, 30, -1, n, f, l);
        check_value("t5_xfers", n, 64);

        // Three ZRLs then a value that overruns index 63
        add_sym(0, 1, 1);
        add_sym(15, 0, 0);
        add_sym(15, 0, 0);
        add_sym(15, 0, 0);
        add_sym(15, 2, 2'b11);
        run_stream(2000, 100, 0, -1, n, f, l);
        check_value("t4_xfers", n, 64);

        // Random symbol mix, including bad sizes and bad size-0 runs
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(99));
            if (r < 15) begin
                k = int'($urandom_range(2));
                add_sym((k == 0) ? 0 : (k == 1) ? 15 : int'($urandom_range(15)), 0, 0);
            end else if (r < 95) begin
                add_sym(int'($urandom_range(15)), int'($urandom_range(11, 1)), int'($urandom));
            end else begin
                add_sym(int'($urandom_range(15)), int'($urandom_range(15, 12)), int'($urandom));
            end
        end
        run_stream(60000, 70, 30, -1, n, f, l);

        // Reset in the middle of a block that has already flagged an error
        do_reset();
        add_sym(0, 5, 7);
        add_sym(3, 0, 0);
        run_stream(500, 100, 0, 20, n, f, l);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_value("pre_rst_index", out_index, 20);
        check_value("pre_rst_err", err, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_value("mid_rst_out_valid", out_valid, 0);
        check_value("mid_rst_err", err, 0);
        check_value("mid_rst_in_ready", in_ready, 1);
        rst = 1'b0;
        clear_model();
        add_sym(0, 3, 6);
        add_sym(0, 0, 0);
        run_stream(2000, 100, 0, -1, n, f, l);
        check_value("post_rst_xfers", n, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
